ex_mem_stage: RTL and testbench
===============================

# ex_mem_stage

EX→MEM pipeline stage of the RV32I core. It is the consumer end of the ALU result interface. It registers the ALU result, zero and less_than flags together with the instruction's control bits, and resolves conditional branches from the flags. It then presents the payload to the MEM stage through a valid/ready handshake, with optional skid buffering. It also drives the redirect and forwarding signals back toward IF/ID.

## Interface
- XLEN, 32, datapath width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous kill of all buffered entries
- ex_valid  in  1  EX payload valid
- ex_ready  out  1  stage can accept
- alu_out  in  XLEN  ALU result
- zero  in  1  ALU zero flag
- less_than  in  1  ALU less-than flag (SLT/SLTU compare)
- store_data  in  XLEN  rs2 value for stores
- rd  in  5  destination register
- funct3  in  3  branch/mem funct3
- is_branch, mem_read, mem_write, reg_write  in  1 each  control bits
- branch_target  in  XLEN  precomputed target
- mem_valid  out  1  payload valid to MEM
- mem_ready  in  1  MEM accepts
- mem_alu_out, mem_store_data  out  XLEN  registered payload
- mem_rd  out  5; mem_funct3  out  3
- mem_mem_read, mem_mem_write, mem_reg_write  out  1 each
- redirect_valid  out  1  one-cycle taken-branch pulse
- redirect_pc  out  XLEN  branch target
- fwd_valid  out  1  mem_valid & mem_reg_write & (mem_rd != 0)
- fwd_rd  out  5; fwd_data  out  XLEN  forwarding to EX

## Operation
- Accept on ex_valid & ex_ready. Transfer out on mem_valid & mem_ready.
- Branch taken, evaluated at accept with is_branch=1:
  - funct3 000 BEQ: zero
  - 001 BNE: !zero
  - 100 BLT / 110 BLTU: less_than
  - 101 BGE / 111 BGEU: !less_than
  - 010 and 011: never taken
- A taken branch sets redirect_valid=1 and redirect_pc=branch_target in the cycle after accept, for exactly one cycle. Not-taken or non-branch instructions give redirect_valid=0.
- A branch entry still passes to MEM unchanged. Its control bits are as supplied, normally reg_write=0.
- Flush clears all entries; mem_valid=0 next cycle. A handshake coinciding with flush is discarded and produces no redirect. A redirect pulse already registered from an earlier accept still fires.
- Simultaneous accept and drain keeps occupancy unchanged. Order is strictly FIFO.
- Reset mid-operation drops everything immediately.
- Reset values: mem_valid=0, redirect_valid=0, all payload outputs 0, fwd_valid=0, ex_ready=1 one cycle after deassert.

## Timing
- Latency: accept at cycle N gives mem_valid at N+1. Redirect also appears at N+1.
- Payload is held stable while mem_valid & !mem_ready.
- fwd_* are combinational from the registered head entry only, with no input-to-output paths.
- Full throughput: one transfer per cycle when mem_ready stays high.

## Configuration
- EX_MEM_SKID_EN defined:
  - 2-entry skid buffer.
  - ex_ready is registered: ex_ready = occupancy < 2.
  - No combinational path from mem_ready to ex_ready.
- Undefined:
  - Single register.
  - ex_ready = !mem_valid | mem_ready, which is combinational.
- Functional ordering, redirect and flush behaviour are identical in both builds.

## Structure
- ex_mem_pkg:
  - ex_mem_payload_t struct holding alu_out, store_data, rd, funct3, mem_read, mem_write and reg_write.
  - Branch funct3 localparams: F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU.
- Sub-module ex_mem_skid: a generic 2-entry valid/ready buffer of ex_mem_payload_t, instantiated only under EX_MEM_SKID_EN.
- Branch resolution stays in ex_mem_stage.

## Test plan
- Reset:
  - Drive rst_n=0 mid-transfer → mem_valid=0, redirect_valid=0 and fwd_valid=0 immediately.
  - After release, ex_ready=1.
- BEQ accept with zero=1, branch_target=0x0000_0100 → next cycle redirect_valid=1 and redirect_pc=0x100 for one cycle only.
  - The same branch with zero=0 → no redirect.
- BGEU/BLTU pair with less_than=1 → BLTU redirects and BGEU does not.
  - funct3=010 → never redirects.
- Backpressure:
  - Hold mem_ready=0 and stream 3 ADD results (0x11, 0x22, 0x33).
  - With the skid build, ex_ready drops after 2 accepts; without it, after 1.
  - Release mem_ready → outputs 0x11, 0x22, 0x33 in order with no loss or duplication.
- Flush while the buffer is full, with an ex_valid handshake in the same cycle → mem_valid=0 next cycle, the flushed-cycle input is absent and no redirect appears.
- Forwarding:
  - rd=5, reg_write=1, alu_out=0xDEAD_BEEF → fwd_valid=1, fwd_rd=5, fwd_data=0xDEADBEEF.
  - The same with rd=0 → fwd_valid=0.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// ============================================================================
// Module   : ex_mem_pkg
// Brief    : Shared types and constants for the EX->MEM pipeline stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ex_mem_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef struct packed {
        logic [XLEN-1:0] alu_out;
        logic [XLEN-1:0] store_data;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic            mem_read;
        logic            mem_write;
        logic            reg_write;
    } ex_mem_payload_t;

    // Signed and unsigned compares share one less_than flag from the ALU.
    function automatic logic branch_taken(
        input logic [2:0] f3,
        input logic       zero_flag,
        input logic       lt_flag
    );
        logic taken;
        taken = 1'b0;
        case (f3)
            F3_BEQ:           taken = zero_flag;
            F3_BNE:           taken = ~zero_flag;
            F3_BLT, F3_BLTU:  taken = lt_flag;
            F3_BGE, F3_BGEU:  taken = ~lt_flag;
            default:          taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ex_mem_skid.sv
// ============================================================================
// Module   : ex_mem_skid
// Brief    : Two-entry FIFO-ordered valid/ready buffer of ex_mem_payload_t;
//            input ready depends only on registered occupancy.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ex_mem_skid
    import ex_mem_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  ex_mem_payload_t i_data,
    output logic            o_valid,
    input  logic            i_ready,
    output ex_mem_payload_t o_data
);

    logic [1:0]      r_count;
    ex_mem_payload_t r_head;
    ex_mem_payload_t r_tail;
    logic            w_push;
    logic            w_pop;

    assign o_ready = (r_count != 2'd2);
    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_head;
    assign w_push  = i_valid & o_ready;
    assign w_pop   = o_valid & i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 2'd0;
            r_head  <= '0;
            r_tail  <= '0;
        end else if (i_flush) begin
            r_count <= 2'd0;
        end else begin
            case (r_count)
                2'd0: begin
                    if (w_push) begin
                        r_head  <= i_data;
                        r_count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        r_head <= i_data;
                    end else if (w_push) begin
                        r_tail  <= i_data;
                        r_count <= 2'd2;
                    end else if (w_pop) begin
                        r_count <= 2'd0;
                    end
                end
                default: begin
                    // Full: no push possible, so only a pop advances the tail.
                    if (w_pop) begin
                        r_head  <= r_tail;
                        r_count <= 2'd1;
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/ex_mem_stage.sv
// ============================================================================
// Module   : ex_mem_stage
// Brief    : EX->MEM pipeline register with branch resolution, redirect and
//            forwarding. Define EX_MEM_SKID_EN for the 2-entry skid buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ex_mem_stage
    import ex_mem_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [XLEN-1:0] alu_out,
    input  logic            zero,
    input  logic            less_than,
    input  logic [XLEN-1:0] store_data,
    input  logic [4:0]      rd,
    input  logic [2:0]      funct3,
    input  logic            is_branch,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            reg_write,
    input  logic [XLEN-1:0] branch_target,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic [XLEN-1:0] mem_alu_out,
    output logic [XLEN-1:0] mem_store_data,
    output logic [4:0]      mem_rd,
    output logic [2:0]      mem_funct3,
    output logic            mem_mem_read,
    output logic            mem_mem_write,
    output logic            mem_reg_write,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            fwd_valid,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data
);

    ex_mem_payload_t w_in_payload;
    ex_mem_payload_t w_head;
    logic            w_accept;
    logic            w_redirect;
    logic            r_redirect_valid;
    logic [XLEN-1:0] r_redirect_pc;

    assign w_in_payload = '{alu_out:    alu_out,
                            store_data: store_data,
                            rd:         rd,
                            funct3:     funct3,
                            mem_read:   mem_read,
                            mem_write:  mem_write,
                            reg_write:  reg_write};

    assign w_accept   = ex_valid & ex_ready;
    assign w_redirect = w_accept & ~flush & is_branch
                      & branch_taken(funct3, zero, less_than);

`ifdef EX_MEM_SKID_EN
    ex_mem_skid u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (flush),
        .i_valid (ex_valid),
        .o_ready (ex_ready),
        .i_data  (w_in_payload),
        .o_valid (mem_valid),
        .i_ready (mem_ready),
        .o_data  (w_head)
    );
`else
    logic            r_valid;
    ex_mem_payload_t r_payload;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_payload <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_payload <= w_in_payload;
        end else if (mem_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign ex_ready  = ~r_valid | mem_ready;
    assign mem_valid = r_valid;
    assign w_head    = r_payload;
`endif

    // Redirect fires once, the cycle after a taken branch is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_redirect_valid <= w_redirect;
            if (w_redirect) begin
                r_redirect_pc <= branch_target;
            end
        end
    end

    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;

    assign mem_alu_out    = w_head.alu_out;
    assign mem_store_data = w_head.store_data;
    assign mem_rd         = w_head.rd;
    assign mem_funct3     = w_head.funct3;
    assign mem_mem_read   = w_head.mem_read;
    assign mem_mem_write  = w_head.mem_write;
    assign mem_reg_write  = w_head.reg_write;

    assign fwd_valid = mem_valid & w_head.reg_write & (w_head.rd != 5'd0);
    assign fwd_rd    = w_head.rd;
    assign fwd_data  = w_head.alu_out;

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
// ============================================================================
// Module   : tb_ex_mem_stage
// Brief    : Self-checking bench for ex_mem_stage against a queue-based model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ex_mem_stage;

`ifdef EX_MEM_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [31:0] alu_out = '0;
    logic        zero = 1'b0;
    logic        less_than = 1'b0;
    logic [31:0] store_data = '0;
    logic [4:0]  rd = '0;
    logic [2:0]  funct3 = '0;
    logic        is_branch = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        reg_write = 1'b0;
    logic [31:0] branch_target = '0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_alu_out;
    logic [31:0] mem_store_data;
    logic [4:0]  mem_rd;
    logic [2:0]  mem_funct3;
    logic        mem_mem_read;
    logic        mem_mem_write;
    logic        mem_reg_write;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .alu_out(alu_out), .zero(zero), .less_than(less_than),
        .store_data(store_data), .rd(rd), .funct3(funct3),
        .is_branch(is_branch), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .branch_target(branch_target),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_alu_out(mem_alu_out), .mem_store_data(mem_store_data),
        .mem_rd(mem_rd), .mem_funct3(mem_funct3),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .mem_reg_write(mem_reg_write),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] alu;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        mr;
        logic        mw;
        logic        rw;
    } ent_t;

    ent_t        q[$];
    logic        e_rv = 1'b0;
    logic [31:0] e_rpc = '0;

    function automatic logic ref_taken(input logic [2:0] f3, input logic z, input logic lt);
        case (f3)
            3'd0:       return z;
            3'd1:       return !z;
            3'd4, 3'd6: return lt;
            3'd5, 3'd7: return !lt;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic model_ready();
        if (CAP == 2) return q.size() < 2;
        return (q.size() == 0) || mem_ready;
    endfunction

    always @(posedge clk or negedge rst_n) begin : m_upd
        logic acc;
        logic drn;
        ent_t e;
        if (!rst_n) begin
            q.delete();
            e_rv = 1'b0;
        end else begin
            acc = ex_valid && model_ready();
            drn = (q.size() > 0) && mem_ready;
            if (flush) begin
                q.delete();
                e_rv = 1'b0;
            end else begin
                if (drn) void'(q.pop_front());
                if (acc) begin
                    e.alu = alu_out; e.sd = store_data; e.rd = rd; e.f3 = funct3;
                    e.mr = mem_read; e.mw = mem_write; e.rw = reg_write;
                    q.push_back(e);
                end
                e_rv = acc && is_branch && ref_taken(funct3, zero, less_than);
                if (e_rv) e_rpc = branch_target;
            end
        end
    end

    always @(negedge clk) begin : m_chk
        ent_t h;
        logic ev;
        ev = q.size() > 0;
        chk("mem_valid", mem_valid, ev);
        chk("ex_ready", ex_ready, model_ready());
        chk("redirect_valid", redirect_valid, e_rv);
        if (e_rv) chk("redirect_pc", redirect_pc, e_rpc);
        if (ev) begin
            h = q[0];
            chk("mem_alu_out", mem_alu_out, h.alu);
            chk("mem_store_data", mem_store_data, h.sd);
            chk("mem_rd", mem_rd, h.rd);
            chk("mem_funct3", mem_funct3, h.f3);
            chk("mem_ctrl", {mem_mem_read, mem_mem_write, mem_reg_write}, {h.mr, h.mw, h.rw});
            chk("fwd_valid", fwd_valid, h.rw && (h.rd != 0));
            if (h.rw && (h.rd != 0)) begin
                chk("fwd_rd", fwd_rd, h.rd);
                chk("fwd_data", fwd_data, h.alu);
            end
        end else begin
            chk("fwd_valid_idle", fwd_valid, 1'b0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic br, input logic [2:0] f3, input logic z, input logic lt,
                         input logic [31:0] alu, input logic [31:0] tgt,
                         input logic [4:0] rdv, input logic rw);
        ex_valid = 1'b1; is_branch = br; funct3 = f3; zero = z; less_than = lt;
        alu_out = alu; store_data = alu ^ 32'h5555_AAAA; branch_target = tgt;
        rd = rdv; reg_write = rw; mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic branch_case(input string nm, input logic [2:0] f3, input logic z,
                               input logic lt, input logic exp_taken);
        mem_ready = 1'b1;
        drive(1'b1, f3, z, lt, 32'h0, 32'h0000_0100, 5'd0, 1'b0);
        step();
        ex_valid = 1'b0;
        #1;
        chk(nm, redirect_valid, exp_taken);
        if (exp_taken) chk({nm, "_pc"}, redirect_pc, 32'h0000_0100);
        step();
        chk({nm, "_pulse_end"}, redirect_valid, 1'b0);
    endtask

    logic [31:0] vals[3];
    logic [31:0] got[$];
    int          sent;

    initial begin
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_ex_ready", ex_ready, 1'b1);
        chk("rst_mem_valid", mem_valid, 1'b0);
        chk("rst_alu_out", mem_alu_out, 32'h0);
        chk("rst_store_data", mem_store_data, 32'h0);
        chk("rst_rd", mem_rd, 5'd0);
        chk("rst_redirect", redirect_valid, 1'b0);
        chk("rst_fwd_valid", fwd_valid, 1'b0);
        step();
        chk("rst_ex_ready_after", ex_ready, 1'b1);

        branch_case("beq_taken", 3'b000, 1'b1, 1'b0, 1'b1);
        branch_case("beq_not",   3'b000, 1'b0, 1'b0, 1'b0);
        branch_case("bne_taken", 3'b001, 1'b0, 1'b0, 1'b1);
        branch_case("bltu_lt",   3'b110, 1'b0, 1'b1, 1'b1);
        branch_case("bgeu_lt",   3'b111, 1'b0, 1'b1, 1'b0);
        branch_case("bge_ge",    3'b101, 1'b0, 1'b0, 1'b1);
        branch_case("blt_ge",    3'b100, 1'b0, 1'b0, 1'b0);
        branch_case("f3_010",    3'b010, 1'b1, 1'b1, 1'b0);

        // Backpressure: stream three results while MEM stalls.
        mem_ready = 1'b0; sent = 0; got.delete();
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 3'b000, 1'b0, 1'b0, vals[sent], 32'h0, 5'd7, 1'b1);
            #1;
            if (ex_ready) sent++;
            step();
        end
        chk("bp_accepts", sent, CAP);
        #1;
        chk("bp_ready_low", ex_ready, 1'b0);
        mem_ready = 1'b1;
        for (int c = 0; c < 20 && got.size() < 3; c++) begin
            if (sent < 3) drive(1'b0, 3'b000, 1'b0, 1'b0, vals[sent], 32'h0, 5'd7, 1'b1);
            else ex_valid = 1'b0;
            #1;
            if (mem_valid && mem_ready) got.push_back(mem_alu_out);
            if (ex_valid && ex_ready) sent++;
            step();
        end
        ex_valid = 1'b0;
        chk("bp_count", got.size(), 3);
        for (int i = 0; i < 3; i++)
            if (got.size() > i) chk("bp_order", got[i], vals[i]);

        // Flush with the buffer full and a same-cycle handshake attempt.
        mem_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 3'b000, 1'b0, 1'b0, 32'hA0 + c, 32'h0, 5'd2, 1'b1);
            #1;
            if (!ex_ready) break;
            step();
        end
        flush = 1'b1; mem_ready = 1'b1;
        drive(1'b1, 3'b000, 1'b1, 1'b0, 32'hBB, 32'h0000_0200, 5'd4, 1'b1);
        step();
        flush = 1'b0; ex_valid = 1'b0; mem_ready = 1'b0;
        #1;
        chk("flush_mem_valid", mem_valid, 1'b0);
        chk("flush_redirect", redirect_valid, 1'b0);
        step();
        chk("flush_absent", mem_valid, 1'b0);

        // Forwarding.
        drive(1'b0, 3'b000, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0, 5'd5, 1'b1);
        step();
        ex_valid = 1'b0;
        #1;
        chk("fwd_valid_rd5", fwd_valid, 1'b1);
        chk("fwd_rd_rd5", fwd_rd, 5'd5);
        chk("fwd_data_rd5", fwd_data, 32'hDEAD_BEEF);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        drive(1'b0, 3'b000, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0, 5'd0, 1'b1);
        step();
        ex_valid = 1'b0;
        #1;
        chk("fwd_valid_rd0", fwd_valid, 1'b0);
        mem_ready = 1'b1;
        step();

        // Asynchronous reset mid-transfer with a redirect pending.
        mem_ready = 1'b0;
        drive(1'b1, 3'b000, 1'b1, 1'b0, 32'h77, 32'h0000_0300, 5'd3, 1'b1);
        step();
        ex_valid = 1'b0;
        #1;
        chk("pre_rst_valid", mem_valid, 1'b1);
        chk("pre_rst_redirect", redirect_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_mem_valid", mem_valid, 1'b0);
        chk("rst_mid_redirect", redirect_valid, 1'b0);
        chk("rst_mid_fwd", fwd_valid, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        chk("rst_mid_ex_ready", ex_ready, 1'b1);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            ex_valid      = ($urandom % 4) != 0;
            mem_ready     = ($urandom % 3) != 0;
            flush         = ($urandom % 40) == 0;
            is_branch     = ($urandom % 3) == 0;
            funct3        = 3'($urandom);
            zero          = 1'($urandom);
            less_than     = 1'($urandom);
            alu_out       = $urandom;
            store_data    = $urandom;
            rd            = 5'($urandom);
            reg_write     = 1'($urandom);
            mem_read      = 1'($urandom);
            mem_write     = 1'($urandom);
            branch_target = $urandom;
            step();
        end
        ex_valid = 1'b0; flush = 1'b0; mem_ready = 1'b1;
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
